// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcode constants and control encodings for multicycle_ctrl
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
  } iclass_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_REG  = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       i_format;
    logic       sftmd;
    logic       jr;
  } exctl_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct decode into instruction class and execute controls
module ctrl_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output exctl_t     ctl
);

  logic r_format;
  logic i_fmt;
  logic is_lw;
  logic is_sw;
  logic is_br;

  assign r_format = (opcode == OP_R);
  assign i_fmt    = (opcode[5:3] == 3'b001);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);

  always_comb begin
    iclass = C_ILL;
    case (opcode)
      OP_R:    iclass = (funct == FN_JR) ? C_JR : C_R;
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_BEQ:  iclass = C_BEQ;
      OP_BNE:  iclass = C_BNE;
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      default: iclass = i_fmt ? C_IALU : C_ILL;
    endcase
  end

  assign ctl.alu_op   = {r_format | i_fmt, is_br};
  assign ctl.alu_src  = i_fmt | is_lw | is_sw;
  assign ctl.i_format = i_fmt;
  assign ctl.sftmd    = r_format && (funct[5:3] == 3'b000);
  assign ctl.jr       = r_format && (funct == FN_JR);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer owning every write-enable of the core
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        Zero,
  output logic [31:0] instr,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic        I_format,
  output logic        Sftmd,
  output logic        Jr,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic        mem_to_reg,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic [2:0]  state
);

  state_t  st;
  iclass_t cls;
  exctl_t  ctl;
  logic [31:0] ir;
  iclass_t dec_cls;
  exctl_t  dec_ctl;
  logic    taken;

  ctrl_decode u_decode (
    .opcode (ir[31:26]),
    .funct  (ir[5:0]),
    .iclass (dec_cls),
    .ctl    (dec_ctl)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st  <= S_FETCH;
      ir  <= '0;
      cls <= C_R;
      ctl <= '0;
    end else begin
      case (st)
        S_FETCH: begin
          if (imem_ready) begin
            ir <= imem_rdata;
            st <= S_DECODE;
          end
        end
        S_DECODE: begin
          cls <= dec_cls;
          ctl <= dec_ctl;
          st  <= S_EXEC;
        end
        S_EXEC: begin
          case (cls)
            C_R, C_IALU, C_JAL: st <= S_WB;
            C_LW, C_SW:         st <= S_MEM;
            default:            st <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) st <= (cls == C_LW) ? S_WB : S_FETCH;
        end
        default: st <= S_FETCH;
      endcase
    end
  end

  assign taken = ((cls == C_BEQ) && Zero) || ((cls == C_BNE) && !Zero);

  // Strobes come straight from state so an async reset kills them in the same cycle.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    illegal    = 1'b0;
    case (st)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        case (cls)
          C_BEQ, C_BNE: begin
            pc_write = 1'b1;
            pc_src   = taken ? PC_BR : PC_SEQ;
          end
          C_J: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
          C_JR: begin
            pc_write = 1'b1;
            pc_src   = PC_REG;
          end
          C_ILL: begin
            illegal  = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SEQ;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_SW);
        pc_write = dmem_ready && (cls == C_SW);
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (cls == C_LW);
        reg_dst    = (cls == C_JAL) ? RD_RA : ((cls == C_R) ? RD_RD : RD_RT);
        pc_src     = (cls == C_JAL) ? PC_JUMP : PC_SEQ;
      end
      default: ;
    endcase
  end

  assign instr    = ir;
  assign state    = st;
  assign ALUOp    = ctl.alu_op;
  assign ALUSrc   = ctl.alu_src;
  assign I_format = ctl.i_format;
  assign Sftmd    = ctl.sftmd;
  assign Jr       = ctl.jr;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_ready;
  logic        Zero;
  logic [31:0] instr;
  logic        imem_req, dmem_req, dmem_we;
  logic [1:0]  ALUOp;
  logic        ALUSrc, I_format, Sftmd, Jr;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic        mem_to_reg, pc_write;
  logic [1:0]  pc_src;
  logic        illegal;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  multicycle_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .Zero       (Zero),
    .instr      (instr),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ALUOp      (ALUOp),
    .ALUSrc     (ALUSrc),
    .I_format   (I_format),
    .Sftmd      (Sftmd),
    .Jr         (Jr),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .state      (state)
  );

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          iw;
    int          dw;
    int          cycles;
    int          rw;
    logic [1:0]  pc_src;
    logic [1:0]  reg_dst;
    logic        m2r;
    int          dcyc;
    logic        dwe;
    int          ill;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        ifmt;
    logic        sftmd;
    logic        jr;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0;
    bit done = 1'b0;
    int rw = 0, dcyc = 0, ill = 0;
    logic dwe = 1'b0, m2r = 1'b0;
    logic [1:0] psrc = 2'b00, rdst = 2'b00, aop = 2'b00;
    logic asrc = 1'b0, ifm = 1'b0, sft = 1'b0, jrr = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clock);
      imem_ready = (cyc == v.iw);
      imem_rdata = (cyc == v.iw) ? v.instr : 32'hDEADBEEF;
      dmem_ready = (cyc >= v.iw + 3 + v.dw);
      Zero       = v.zero;
      #1;
      if (reg_write) begin
        rw++;
        rdst = reg_dst;
        m2r  = mem_to_reg;
      end
      if (dmem_req) dcyc++;
      if (dmem_req && dmem_we) dwe = 1'b1;
      if (illegal) ill++;
      if (pc_write) begin
        done = 1'b1;
        psrc = pc_src;
        aop  = ALUOp;
        asrc = ALUSrc;
        ifm  = I_format;
        sft  = Sftmd;
        jrr  = Jr;
      end
      cyc++;
    end
    chk("finished", idx, 32'(done), 32'd1);
    chk("cycles", idx, cyc, v.cycles);
    chk("reg_write_cnt", idx, rw, v.rw);
    chk("pc_src", idx, 32'(psrc), 32'(v.pc_src));
    chk("reg_dst", idx, 32'(rdst), 32'(v.reg_dst));
    chk("mem_to_reg", idx, 32'(m2r), 32'(v.m2r));
    chk("dmem_req_cycles", idx, dcyc, v.dcyc);
    chk("dmem_we", idx, 32'(dwe), 32'(v.dwe));
    chk("illegal_cnt", idx, ill, v.ill);
    chk("ALUOp", idx, 32'(aop), 32'(v.aluop));
    chk("ALUSrc", idx, 32'(asrc), 32'(v.alusrc));
    chk("I_format", idx, 32'(ifm), 32'(v.ifmt));
    chk("Sftmd", idx, 32'(sft), 32'(v.sftmd));
    chk("Jr", idx, 32'(jrr), 32'(v.jr));
    chk("instr", idx, instr, v.instr);
  endtask

  initial begin
    int strobes;
    //            instr       z     iw dw cyc rw pcs    rdst   m2r  dc we    il aop    src   if    sf    jr
    vecs[0]  = '{32'h00851020, 1'b0, 0, 0, 4,  1, 2'b00, 2'b01, 1'b0, 0, 1'b0, 0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h00851020, 1'b0, 1, 0, 5,  1, 2'b00, 2'b01, 1'b0, 0, 1'b0, 0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h8C820004, 1'b0, 2, 3, 10, 1, 2'b00, 2'b00, 1'b1, 4, 1'b0, 0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'hAC820004, 1'b0, 0, 0, 4,  0, 2'b00, 2'b00, 1'b0, 1, 1'b1, 0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'hAC820004, 1'b0, 0, 2, 6,  0, 2'b00, 2'b00, 1'b0, 3, 1'b1, 0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h10850003, 1'b1, 0, 0, 3,  0, 2'b01, 2'b00, 1'b0, 0, 1'b0, 0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h10850003, 1'b0, 0, 0, 3,  0, 2'b00, 2'b00, 1'b0, 0, 1'b0, 0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h14850003, 1'b0, 0, 0, 3,  0, 2'b01, 2'b00, 1'b0, 0, 1'b0, 0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h14850003, 1'b1, 0, 0, 3,  0, 2'b00, 2'b00, 1'b0, 0, 1'b0, 0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h08000010, 1'b0, 0, 0, 3,  0, 2'b10, 2'b00, 1'b0, 0, 1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h0C000010, 1'b0, 0, 0, 4,  1, 2'b10, 2'b10, 1'b0, 0, 1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h03E00008, 1'b0, 0, 0, 3,  0, 2'b11, 2'b00, 1'b0, 0, 1'b0, 0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{32'h20850005, 1'b0, 0, 0, 4,  1, 2'b00, 2'b00, 1'b0, 0, 1'b0, 0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{32'h00051080, 1'b0, 0, 0, 4,  1, 2'b00, 2'b01, 1'b0, 0, 1'b0, 0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{32'hFC000000, 1'b1, 0, 0, 3,  0, 2'b00, 2'b00, 1'b0, 0, 1'b0, 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

    reset_n    = 1'b0;
    imem_rdata = 32'h0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    Zero       = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_state", 0, 32'(state), 32'd0);
    chk("rst_imem_req", 0, 32'(imem_req), 32'd1);
    chk("rst_instr", 0, instr, 32'h0);
    chk("rst_strobes", 0, 32'({dmem_req, dmem_we, reg_write, pc_write, illegal}), 32'd0);
    chk("rst_ctl", 0, 32'({ALUOp, ALUSrc, I_format, Sftmd, Jr, reg_dst, mem_to_reg, pc_src}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // sw parked in MEM, then reset lands mid-access
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      imem_ready = (c == 0);
      imem_rdata = 32'hAC820004;
      dmem_ready = 1'b0;
    end
    #1;
    chk("midmem_state", 0, 32'(state), 32'd3);
    chk("midmem_dmem", 0, 32'({dmem_req, dmem_we}), 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rstmem_state", 0, 32'(state), 32'd0);
    chk("rstmem_dmem_req", 0, 32'({dmem_req, dmem_we}), 32'd0);
    chk("rstmem_imem_req", 0, 32'(imem_req), 32'd1);
    chk("rstmem_instr", 0, instr, 32'h0);
    dmem_ready = 1'b1;
    imem_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      #1;
      if (pc_write || reg_write || dmem_req) strobes++;
    end
    chk("rstmem_no_strobe", 0, strobes, 0);
    chk("rstmem_hold_fetch", 0, 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
